// File: rtl/risc16_ctrl_fsm_if.sv
// Control bundle between the RiSC-16 sequencer (master) and the memories/datapath (slave).
// RISC16_PERF_CNT_EN adds the cycle_cnt/instret_cnt performance counters to the bundle.
interface risc16_ctrl_fsm_if;
    logic        run;
    logic [15:0] instr;
    logic        imem_ack;
    logic        dmem_ack;
    logic        alu_zero;
    logic        imem_req;
    logic        ir_load;
    logic        pc_en;
    logic [1:0]  pc_sel;
    logic [1:0]  alu_op;
    logic        alu_src_imm;
    logic        rf_we;
    logic [1:0]  rf_wsel;
    logic        dmem_req;
    logic        dmem_we;
    logic        halted;
    logic        fault;
`ifdef RISC16_PERF_CNT_EN
    logic [31:0] cycle_cnt;
    logic [31:0] instret_cnt;

    modport master (
        input  run, instr, imem_ack, dmem_ack, alu_zero,
        output imem_req, ir_load, pc_en, pc_sel, alu_op, alu_src_imm,
               rf_we, rf_wsel, dmem_req, dmem_we, halted, fault,
               cycle_cnt, instret_cnt
    );
    modport slave (
        output run, instr, imem_ack, dmem_ack, alu_zero,
        input  imem_req, ir_load, pc_en, pc_sel, alu_op, alu_src_imm,
               rf_we, rf_wsel, dmem_req, dmem_we, halted, fault,
               cycle_cnt, instret_cnt
    );
`else
    modport master (
        input  run, instr, imem_ack, dmem_ack, alu_zero,
        output imem_req, ir_load, pc_en, pc_sel, alu_op, alu_src_imm,
               rf_we, rf_wsel, dmem_req, dmem_we, halted, fault
    );
    modport slave (
        output run, instr, imem_ack, dmem_ack, alu_zero,
        input  imem_req, ir_load, pc_en, pc_sel, alu_op, alu_src_imm,
               rf_we, rf_wsel, dmem_req, dmem_we, halted, fault
    );
`endif
endinterface

// File: rtl/risc16_ctrl_fsm.sv
// RiSC-16 multi-cycle control FSM; optional RISC16_PERF_CNT_EN adds cycle/instret counters.
// 4 cycles FETCH-to-pc_en (5 for LW/SW), +1 per imem/dmem wait cycle; watchdog halts on stalled ack.
module risc16_ctrl_fsm #(
    parameter int TIMEOUT   = 255,
    parameter int TIMEOUT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    risc16_ctrl_fsm_if.master bus
);
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_ADDI = 3'b001;
    localparam logic [2:0] OP_NAND = 3'b010;
    localparam logic [2:0] OP_LUI  = 3'b011;
    localparam logic [2:0] OP_SW   = 3'b100;
    localparam logic [2:0] OP_LW   = 3'b101;
    localparam logic [2:0] OP_BEQ  = 3'b110;
    localparam logic [2:0] OP_JALR = 3'b111;

    localparam bit                   WD_EN   = (TIMEOUT > 0);
    localparam logic [TIMEOUT_W-1:0] WD_LAST = TIMEOUT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t               state, state_n;
    logic [15:0]          ir, ir_n;
    logic                 take_br, take_br_n;
    logic [TIMEOUT_W-1:0] wd_cnt, wd_cnt_n;
    logic                 wd_hit, wd_expire;
    logic [2:0]           op, op_n;

    logic       imem_req_n, pc_en_n, alu_src_imm_n, rf_we_n;
    logic       dmem_req_n, dmem_we_n, halted_n, fault_n;
    logic [1:0] pc_sel_n, alu_op_n, rf_wsel_n;

    assign op      = ir[15:13];
    assign op_n    = ir_n[15:13];
    assign wd_hit  = WD_EN && (wd_cnt == WD_LAST);

    assign bus.ir_load = (state == FETCH) && bus.imem_ack;

    // Next state; an ack in the expiry cycle takes priority over the watchdog.
    always_comb begin
        state_n   = state;
        ir_n      = ir;
        take_br_n = take_br;
        wd_cnt_n  = wd_cnt + 1'b1;
        wd_expire = 1'b0;
        case (state)
            IDLE:   if (bus.run) state_n = FETCH;
            FETCH: begin
                if (bus.imem_ack) begin
                    ir_n    = bus.instr;
                    state_n = DECODE;
                end else if (wd_hit) begin
                    wd_expire = 1'b1;
                    state_n   = HALT;
                end
            end
            DECODE: state_n = (op == OP_JALR && ir[6:0] != 7'd0) ? HALT : EXEC;
            EXEC: begin
                take_br_n = bus.alu_zero;
                state_n   = (op == OP_LW || op == OP_SW) ? MEM : WB;
            end
            MEM: begin
                if (bus.dmem_ack) begin
                    state_n = WB;
                end else if (wd_hit) begin
                    wd_expire = 1'b1;
                    state_n   = HALT;
                end
            end
            WB:      state_n = bus.run ? FETCH : IDLE;
            HALT:    state_n = HALT;
            default: state_n = IDLE;
        endcase
        if (state_n != state && (state_n == FETCH || state_n == MEM)) wd_cnt_n = '0;
    end

    // Moore decode of the upcoming state so every strobe leaves a flop.
    always_comb begin
        imem_req_n    = (state_n == FETCH);
        pc_en_n       = (state_n == WB);
        dmem_req_n    = (state_n == MEM);
        dmem_we_n     = (state_n == MEM) && (op_n == OP_SW);
        halted_n      = (state_n == HALT);
        fault_n       = bus.fault | wd_expire;
        pc_sel_n      = 2'b00;
        alu_op_n      = 2'b00;
        alu_src_imm_n = 1'b0;
        rf_we_n       = 1'b0;
        rf_wsel_n     = 2'b00;
        if (state_n == EXEC) begin
            case (op_n)
                OP_ADDI, OP_SW, OP_LW: alu_src_imm_n = 1'b1;
                OP_NAND:               alu_op_n = 2'b01;
                OP_LUI: begin
                    alu_op_n      = 2'b10;
                    alu_src_imm_n = 1'b1;
                end
                OP_BEQ:                alu_op_n = 2'b11;
                OP_JALR:               alu_op_n = 2'b10;
                default:               alu_op_n = 2'b00;
            endcase
        end
        if (state_n == WB) begin
            case (op_n)
                OP_ADD, OP_ADDI, OP_NAND, OP_LUI: rf_we_n = 1'b1;
                OP_LW: begin
                    rf_we_n   = 1'b1;
                    rf_wsel_n = 2'b01;
                end
                OP_JALR: begin
                    rf_we_n   = 1'b1;
                    rf_wsel_n = 2'b10;
                    pc_sel_n  = 2'b10;
                end
                OP_BEQ:  pc_sel_n = take_br_n ? 2'b01 : 2'b00;
                default: rf_we_n = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            ir              <= '0;
            take_br         <= 1'b0;
            wd_cnt          <= '0;
            bus.imem_req    <= 1'b0;
            bus.pc_en       <= 1'b0;
            bus.pc_sel      <= 2'b00;
            bus.alu_op      <= 2'b00;
            bus.alu_src_imm <= 1'b0;
            bus.rf_we       <= 1'b0;
            bus.rf_wsel     <= 2'b00;
            bus.dmem_req    <= 1'b0;
            bus.dmem_we     <= 1'b0;
            bus.halted      <= 1'b0;
            bus.fault       <= 1'b0;
        end else begin
            state           <= state_n;
            ir              <= ir_n;
            take_br         <= take_br_n;
            wd_cnt          <= wd_cnt_n;
            bus.imem_req    <= imem_req_n;
            bus.pc_en       <= pc_en_n;
            bus.pc_sel      <= pc_sel_n;
            bus.alu_op      <= alu_op_n;
            bus.alu_src_imm <= alu_src_imm_n;
            bus.rf_we       <= rf_we_n;
            bus.rf_wsel     <= rf_wsel_n;
            bus.dmem_req    <= dmem_req_n;
            bus.dmem_we     <= dmem_we_n;
            bus.halted      <= halted_n;
            bus.fault       <= fault_n;
        end
    end

`ifdef RISC16_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.cycle_cnt   <= '0;
            bus.instret_cnt <= '0;
        end else begin
            if (state != IDLE && state != HALT) bus.cycle_cnt <= bus.cycle_cnt + 32'd1;
            if (bus.pc_en) bus.instret_cnt <= bus.instret_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_risc16_ctrl_fsm.sv
// Self-checking bench for risc16_ctrl_fsm: scoreboarded instruction sequences, reset, halt and watchdog.
`timescale 1ns/1ps
module tb_risc16_ctrl_fsm;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   cyc_now = 0;

    risc16_ctrl_fsm_if bus();
    risc16_ctrl_fsm #(.TIMEOUT(4), .TIMEOUT_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc_now <= cyc_now + 1;

    typedef struct {
        logic [15:0] ins; int iw; int dw; logic z;
        logic [1:0] alu_op; logic alu_src; logic [1:0] pc_sel; logic rf_we; logic [1:0] rf_wsel;
        int lat; int dreq; logic dwe;
    } exp_t;
    typedef struct {
        bit done; int lat; int at;
        logic [1:0] alu_op; logic alu_src; logic [1:0] pc_sel; logic rf_we; logic [1:0] rf_wsel;
        int dreq; logic dwe; logic ir_load;
    } obs_t;

    exp_t sb[$];

    function automatic logic [14:0] outs();
        return {bus.imem_req, bus.ir_load, bus.pc_en, bus.pc_sel, bus.alu_op, bus.alu_src_imm,
                bus.rf_we, bus.rf_wsel, bus.dmem_req, bus.dmem_we, bus.halted, bus.fault};
    endfunction

    function automatic exp_t mk(logic [15:0] ins, int iw, int dw, logic z, logic [1:0] aop, logic asrc,
                                logic [1:0] ps, logic we, logic [1:0] ws, int lat, int dreq, logic dwe);
        exp_t e;
        e.ins = ins; e.iw = iw; e.dw = dw; e.z = z; e.alu_op = aop; e.alu_src = asrc;
        e.pc_sel = ps; e.rf_we = we; e.rf_wsel = ws; e.lat = lat; e.dreq = dreq; e.dwe = dwe;
        return e;
    endfunction

    // Plays the memory side for one instruction and records what the DUT did.
    task automatic exec_instr(input exp_t e, input bit drop_run, output obs_t o);
        int cyc = 0;
        int icnt = 0;
        int dcnt = 0;
        bit started = 1'b0;
        o.done = 1'b0; o.lat = 0; o.at = 0; o.alu_op = 2'b00; o.alu_src = 1'b0; o.pc_sel = 2'b00;
        o.rf_we = 1'b0; o.rf_wsel = 2'b00; o.dreq = 0; o.dwe = 1'b0; o.ir_load = 1'b0;
        bus.alu_zero = e.z;
        for (int i = 0; i < 60 && !o.done; i++) begin
            @(negedge clk);
            if (bus.imem_req) started = 1'b1;
            if (started) cyc++;
            if (cyc == e.iw + 3) begin
                o.alu_op  = bus.alu_op;
                o.alu_src = bus.alu_src_imm;
            end
            if (bus.pc_en) begin
                o.done = 1'b1; o.lat = cyc; o.at = cyc_now;
                o.pc_sel = bus.pc_sel; o.rf_we = bus.rf_we; o.rf_wsel = bus.rf_wsel;
            end
            if (bus.dmem_req) begin
                dcnt++; o.dreq++;
                o.dwe = o.dwe | bus.dmem_we;
                bus.dmem_ack = (dcnt == e.dw + 1);
            end else bus.dmem_ack = 1'b0;
            if (bus.imem_req) begin
                icnt++;
                bus.instr    = e.ins;
                bus.imem_ack = (icnt == e.iw + 1);
                if (drop_run) bus.run = 1'b0;
            end else bus.imem_ack = 1'b0;
            if (bus.imem_ack) begin
                #1;
                o.ir_load = bus.ir_load;
            end
        end
    endtask

    task automatic test_reset();
        bit seen = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (outs() !== 15'd0) begin
            errors++; $display("FAIL reset_outputs got=%h exp=0", outs());
        end
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.imem_req || bus.pc_en) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++; $display("FAIL reset_idle_run0 got=%0d exp=0", seen);
        end
    endtask

    task automatic test_back_to_back();
        obs_t o;
        exp_t e;
        int last_at = 0;
        bus.run = 1'b1;
        for (int k = 0; k < 3; k++) begin
            sb.push_back(mk(16'h0401, 0, 0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 2'b00, 4, 0, 1'b0));
            exec_instr(sb[0], 1'b0, o);
            e = sb.pop_front();
            checks++;
            if (!o.done || o.lat != e.lat) begin
                errors++; $display("FAIL b2b_lat[%0d] got=%0d exp=%0d", k, o.lat, e.lat);
            end
            checks++;
            if ({o.pc_sel, o.rf_we, o.rf_wsel} !== {e.pc_sel, e.rf_we, e.rf_wsel}) begin
                errors++; $display("FAIL b2b_wb[%0d] got=%b exp=%b", k,
                                   {o.pc_sel, o.rf_we, o.rf_wsel}, {e.pc_sel, e.rf_we, e.rf_wsel});
            end
            if (k > 0) begin
                checks++;
                if (o.at - last_at != 4) begin
                    errors++; $display("FAIL b2b_period[%0d] got=%0d exp=4", k, o.at - last_at);
                end
            end
            last_at = o.at;
        end
    endtask

    task automatic test_instr_table();
        exp_t tbl[10];
        exp_t e;
        obs_t o;
        tbl[0] = mk(16'h0401, 0, 0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 2'b00, 4, 0, 1'b0);
        tbl[1] = mk(16'h2401, 0, 0, 1'b0, 2'b00, 1'b1, 2'b00, 1'b1, 2'b00, 4, 0, 1'b0);
        tbl[2] = mk(16'h4401, 0, 0, 1'b0, 2'b01, 1'b0, 2'b00, 1'b1, 2'b00, 4, 0, 1'b0);
        tbl[3] = mk(16'h6401, 0, 0, 1'b0, 2'b10, 1'b1, 2'b00, 1'b1, 2'b00, 4, 0, 1'b0);
        tbl[4] = mk(16'h8405, 0, 0, 1'b0, 2'b00, 1'b1, 2'b00, 1'b0, 2'b00, 5, 1, 1'b1);
        tbl[5] = mk(16'hA405, 0, 3, 1'b0, 2'b00, 1'b1, 2'b00, 1'b1, 2'b01, 8, 4, 1'b0);
        tbl[6] = mk(16'hC40E, 0, 0, 1'b1, 2'b11, 1'b0, 2'b01, 1'b0, 2'b00, 4, 0, 1'b0);
        tbl[7] = mk(16'hC40E, 0, 0, 1'b0, 2'b11, 1'b0, 2'b00, 1'b0, 2'b00, 4, 0, 1'b0);
        tbl[8] = mk(16'hE400, 0, 0, 1'b0, 2'b10, 1'b0, 2'b10, 1'b1, 2'b10, 4, 0, 1'b0);
        tbl[9] = mk(16'h2401, 2, 0, 1'b0, 2'b00, 1'b1, 2'b00, 1'b1, 2'b00, 6, 0, 1'b0);
        bus.run = 1'b1;
        for (int i = 0; i < 10; i++) begin
            sb.push_back(tbl[i]);
            exec_instr(tbl[i], 1'b0, o);
            e = sb.pop_front();
            checks++;
            if (!o.done || o.lat != e.lat) begin
                errors++; $display("FAIL tbl%0d_latency got=%0d exp=%0d", i, o.lat, e.lat);
            end
            checks++;
            if ({o.alu_op, o.alu_src} !== {e.alu_op, e.alu_src}) begin
                errors++; $display("FAIL tbl%0d_alu got=%b exp=%b", i, {o.alu_op, o.alu_src}, {e.alu_op, e.alu_src});
            end
            checks++;
            if (o.pc_sel !== e.pc_sel) begin
                errors++; $display("FAIL tbl%0d_pc_sel got=%b exp=%b", i, o.pc_sel, e.pc_sel);
            end
            checks++;
            if ({o.rf_we, o.rf_wsel} !== {e.rf_we, e.rf_wsel}) begin
                errors++; $display("FAIL tbl%0d_rf got=%b exp=%b", i, {o.rf_we, o.rf_wsel}, {e.rf_we, e.rf_wsel});
            end
            checks++;
            if (o.dreq != e.dreq || o.dwe !== e.dwe) begin
                errors++; $display("FAIL tbl%0d_dmem got=%0d/%b exp=%0d/%b", i, o.dreq, o.dwe, e.dreq, e.dwe);
            end
            checks++;
            if (o.ir_load !== 1'b1) begin
                errors++; $display("FAIL tbl%0d_ir_load got=%b exp=1", i, o.ir_load);
            end
        end
    endtask

    task automatic test_run_drop();
        obs_t o;
        exp_t e;
        bit seen = 1'b0;
        sb.push_back(mk(16'hE400, 0, 0, 1'b0, 2'b10, 1'b0, 2'b10, 1'b1, 2'b10, 4, 0, 1'b0));
        exec_instr(sb[0], 1'b1, o);
        e = sb.pop_front();
        checks++;
        if (!o.done || o.lat != e.lat || o.pc_sel !== e.pc_sel) begin
            errors++; $display("FAIL run_drop_complete got=%0d/%b exp=%0d/%b", o.lat, o.pc_sel, e.lat, e.pc_sel);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.imem_req || bus.pc_en) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++; $display("FAIL run_drop_idle got=%0d exp=0", seen);
        end
    endtask

    task automatic test_reset_mid_mem();
        bit hit = 1'b0;
        bit seen = 1'b0;
        bus.run = 1'b1;
        for (int i = 0; i < 20 && !hit; i++) begin
            @(negedge clk);
            if (bus.dmem_req) hit = 1'b1;
            else begin
                bus.instr    = 16'h8405;
                bus.imem_ack = bus.imem_req;
                bus.dmem_ack = 1'b0;
            end
        end
        checks++;
        if (hit !== 1'b1 || bus.dmem_we !== 1'b1) begin
            errors++; $display("FAIL mid_mem_reach got=%b/%b exp=1/1", hit, bus.dmem_we);
        end
        #2;
        rst = 1'b1; bus.run = 1'b0; bus.imem_ack = 1'b0;
        #1;
        checks++;
        if (outs() !== 15'd0) begin
            errors++; $display("FAIL mid_mem_reset_outputs got=%h exp=0", outs());
        end
`ifdef RISC16_PERF_CNT_EN
        checks++;
        if (bus.cycle_cnt !== 32'd0 || bus.instret_cnt !== 32'd0) begin
            errors++; $display("FAIL mid_mem_reset_counters got=%0d/%0d exp=0/0", bus.cycle_cnt, bus.instret_cnt);
        end
`endif
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.imem_req || bus.pc_en || bus.dmem_req) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++; $display("FAIL mid_mem_post_reset_idle got=%0d exp=0", seen);
        end
    endtask

    task automatic test_halt();
        int cyc = 0;
        int halt_at = 0;
        bit pc_seen = 1'b0;
        bit bad = 1'b0;
        bus.run = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.imem_req || cyc > 0) cyc++;
            if (bus.halted && halt_at == 0) halt_at = cyc;
            if (bus.pc_en) pc_seen = 1'b1;
            bus.instr    = 16'hE001;
            bus.imem_ack = bus.imem_req;
        end
        checks++;
        if (halt_at != 3) begin
            errors++; $display("FAIL halt_cycle got=%0d exp=3", halt_at);
        end
        bus.imem_ack = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (!bus.halted || bus.imem_req || bus.fault || bus.pc_en) bad = 1'b1;
        end
        checks++;
        if (pc_seen !== 1'b0 || bad !== 1'b0) begin
            errors++; $display("FAIL halt_absorbing got=%b/%b exp=0/0", pc_seen, bad);
        end
        bus.imem_ack = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.halted !== 1'b0) begin
            errors++; $display("FAIL halt_cleared_by_rst got=%b exp=0", bus.halted);
        end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_timeout();
        int req_cnt = 0;
        bus.imem_ack = 1'b0;
        bus.run = 1'b1;
        for (int i = 0; i < 15 && !bus.halted; i++) begin
            @(negedge clk);
            if (bus.imem_req) req_cnt++;
        end
        checks++;
        if (req_cnt != 4) begin
            errors++; $display("FAIL timeout_req_cycles got=%0d exp=4", req_cnt);
        end
        checks++;
        if ({bus.fault, bus.halted, bus.imem_req, bus.pc_en} !== 4'b1100) begin
            errors++; $display("FAIL timeout_state got=%b exp=1100", {bus.fault, bus.halted, bus.imem_req, bus.pc_en});
        end
`ifdef RISC16_PERF_CNT_EN
        checks++;
        if (bus.instret_cnt !== 32'd0 || bus.cycle_cnt !== 32'd4) begin
            errors++; $display("FAIL timeout_counters got=%0d/%0d exp=0/4", bus.instret_cnt, bus.cycle_cnt);
        end
`endif
        rst = 1'b1; bus.run = 1'b0;
        #1;
        checks++;
        if (bus.fault !== 1'b0) begin
            errors++; $display("FAIL fault_cleared_by_rst got=%b exp=0", bus.fault);
        end
        @(negedge clk); rst = 1'b0;
    endtask

    initial begin
        bus.run = 1'b0; bus.instr = 16'h0000; bus.imem_ack = 1'b0;
        bus.dmem_ack = 1'b0; bus.alu_zero = 1'b0;
        #1;
        test_reset();
        test_back_to_back();
        test_instr_table();
        test_run_drop();
        test_reset_mid_mem();
        test_halt();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
